// File: rtl/hist_eq_remap_if.sv
// hist_eq_remap_if: video in/out streams plus LUT load/swap controls for hist_eq_remap.
interface hist_eq_remap_if #(
  parameter int N = 8
);
  logic [N-1:0] i_video_tdata;
  logic         i_video_tvalid;
  logic         i_video_tlast;
  logic         i_video_tuser;
  logic         o_video_tready;

  logic [N-1:0] o_reg_video_tdata;
  logic         o_reg_video_tvalid;
  logic         o_reg_video_tlast;
  logic         o_reg_video_tuser;
  logic         i_reg_video_tready;

  logic         i_lut_wr_en;
  logic [N-1:0] i_lut_wr_addr;
  logic [N-1:0] i_lut_wr_data;
  logic         i_lut_swap;
  logic         o_lut_bank;
  logic         o_frame_err;

  modport slave (
    input  i_video_tdata, i_video_tvalid, i_video_tlast, i_video_tuser,
    output o_video_tready,
    output o_reg_video_tdata, o_reg_video_tvalid, o_reg_video_tlast, o_reg_video_tuser,
    input  i_reg_video_tready,
    input  i_lut_wr_en, i_lut_wr_addr, i_lut_wr_data, i_lut_swap,
    output o_lut_bank, o_frame_err
  );

  modport master (
    output i_video_tdata, i_video_tvalid, i_video_tlast, i_video_tuser,
    input  o_video_tready,
    input  o_reg_video_tdata, o_reg_video_tvalid, o_reg_video_tlast, o_reg_video_tuser,
    output i_reg_video_tready,
    output i_lut_wr_en, i_lut_wr_addr, i_lut_wr_data, i_lut_swap,
    input  o_lut_bank, o_frame_err
  );
endinterface

// File: rtl/hist_eq_remap.sv
// hist_eq_remap: maps every pixel of an AXI4-Stream frame through a double-buffered
// 2^N x N equalisation LUT. New tables are loaded into the inactive bank and swapped
// in on the next start-of-frame beat. Two registered stages, stall-together pipe.
// Define HIST_EQ_REMAP_FRAME_CHECK_EN to build the pixel/line framing checker that
// drives o_frame_err; otherwise o_frame_err is tied low.
module hist_eq_remap #(
  parameter int N      = 8,
  parameter int WIDTH  = 355,
  parameter int HEIGHT = 355
) (
  input logic           i_sys_clk,
  input logic           i_sys_areset,
  hist_eq_remap_if.slave bus
);
  localparam int DEPTH = 2 ** N;

  // The framing counters are 11 bits wide.
  if (WIDTH < 1 || WIDTH > 2048 || HEIGHT < 1 || HEIGHT > 2048) begin : g_size_check
    $error("hist_eq_remap: WIDTH/HEIGHT must be within 1..2048");
  end

  logic         en;
  logic         accept;
  logic         swap_now;
  logic         bank_q, bank_d;
  logic         pending_q, pending_d;

  logic         v1_q;
  logic [N-1:0] pix1_q;
  logic         last1_q, user1_q, bank1_q;

  logic         v2_q;
  logic [N-1:0] data2_q;
  logic         last2_q, user2_q;

  // Entries hold value ^ address, so the all-zero configured state reads as identity.
  logic [N-1:0] lut_q [2*DEPTH];
  logic [N-1:0] map_data;

  assign en       = ~v2_q | bus.i_reg_video_tready;
  assign accept   = bus.i_video_tvalid & en;
  assign swap_now = accept & bus.i_video_tuser & (pending_q | bus.i_lut_swap);
  assign map_data = lut_q[{bank1_q, pix1_q}] ^ pix1_q;

  // Next bank / pending-swap state: a swap only takes effect on an accepted tuser beat.
  always_comb begin
    bank_d    = bank_q;
    pending_d = pending_q | bus.i_lut_swap;
    if (swap_now) begin
      bank_d    = ~bank_q;
      pending_d = 1'b0;
    end
  end

  // Table writes always target the bank that is inactive in this cycle.
  always_ff @(posedge i_sys_clk) begin
    if (bus.i_lut_wr_en) begin
      lut_q[{~bank_q, bus.i_lut_wr_addr}] <= bus.i_lut_wr_data ^ bus.i_lut_wr_addr;
    end
  end

  // Bank select and the two pipeline stages; both stages advance only when en is high.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      bank_q    <= 1'b0;
      pending_q <= 1'b0;
      v1_q      <= 1'b0;
      pix1_q    <= '0;
      last1_q   <= 1'b0;
      user1_q   <= 1'b0;
      bank1_q   <= 1'b0;
      v2_q      <= 1'b0;
      data2_q   <= '0;
      last2_q   <= 1'b0;
      user2_q   <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      pending_q <= pending_d;
      if (en) begin
        v1_q <= bus.i_video_tvalid;
        if (bus.i_video_tvalid) begin
          pix1_q  <= bus.i_video_tdata;
          last1_q <= bus.i_video_tlast;
          user1_q <= bus.i_video_tuser;
          bank1_q <= bank_d;
        end
        v2_q <= v1_q;
        if (v1_q) begin
          data2_q <= map_data;
          last2_q <= last1_q;
          user2_q <= user1_q;
        end
      end
    end
  end

  assign bus.o_video_tready     = en;
  assign bus.o_reg_video_tvalid = v2_q;
  assign bus.o_reg_video_tdata  = data2_q;
  assign bus.o_reg_video_tlast  = last2_q;
  assign bus.o_reg_video_tuser  = user2_q;
  assign bus.o_lut_bank         = bank_q;

`ifdef HIST_EQ_REMAP_FRAME_CHECK_EN
  logic [10:0] pix_q, line_q;
  logic [10:0] pix_eff, line_eff;
  logic        eol;
  logic        err_d;
  logic        frame_err_q;

  // A received tuser resyncs the position to (0,0); end of line on tlast or on the last column.
  always_comb begin
    pix_eff  = bus.i_video_tuser ? 11'd0 : pix_q;
    line_eff = bus.i_video_tuser ? 11'd0 : line_q;
    eol      = bus.i_video_tlast | (pix_eff == 11'(WIDTH - 1));
    err_d    = accept &
               ((bus.i_video_tuser != ((pix_q == 11'd0) && (line_q == 11'd0))) |
                (bus.i_video_tlast != (pix_eff == 11'(WIDTH - 1))));
  end

  // Position counters and the one-cycle error pulse.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      pix_q       <= '0;
      line_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= err_d;
      if (accept) begin
        if (eol) begin
          pix_q  <= '0;
          line_q <= (line_eff == 11'(HEIGHT - 1)) ? 11'd0 : 11'(line_eff + 11'd1);
        end else begin
          pix_q  <= 11'(pix_eff + 11'd1);
          line_q <= line_eff;
        end
      end
    end
  end

  assign bus.o_frame_err = frame_err_q;
`else
  assign bus.o_frame_err = 1'b0;
`endif
endmodule
